// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: serially loads a pattern, pulses one functional
// capture cycle, then unloads the response into a parallel register.
module scan_chain_ctrl #(
   parameter int CHAIN_LEN = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic                 ABORT,
   input  logic [CHAIN_LEN-1:0] PAT_IN,
   input  logic                 SO,
   output logic                 SE,
   output logic                 SI,
   output logic                 BUSY,
   output logic                 DONE,
   output logic [CHAIN_LEN-1:0] RESP
);
   localparam int CNT_W = $clog2(CHAIN_LEN);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_CAPTURE,
      S_UNLOAD,
      S_FINISH
   } state_t;

   state_t               state_reg, state_next;
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   logic [CHAIN_LEN-1:0] pat_reg, pat_next;
   logic [CHAIN_LEN-1:0] shadow_reg, shadow_next;
   logic [CHAIN_LEN-1:0] resp_reg, resp_next;
   logic [CNT_W-1:0]     rev_idx;

   // Both load and unload walk the chain from its tail position downwards.
   assign rev_idx = LAST - cnt_reg;

   genvar gi;
   generate
      for (gi = 0; gi < CHAIN_LEN; gi++) begin : g_shadow
         assign shadow_next[gi] = (state_reg == S_UNLOAD && rev_idx == CNT_W'(gi))
                                  ? SO : shadow_reg[gi];
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         pat_reg    <= '0;
         shadow_reg <= '0;
         resp_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         pat_reg    <= pat_next;
         shadow_reg <= shadow_next;
         resp_reg   <= resp_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pat_next   = pat_reg;
      resp_next  = resp_reg;
      case (state_reg)
         S_IDLE: begin
            if (START) begin
               pat_next   = PAT_IN;
               cnt_next   = '0;
               state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (ABORT) begin
               cnt_next   = '0;
               state_next = S_IDLE;
            end else if (cnt_reg == LAST) begin
               cnt_next   = '0;
               state_next = S_CAPTURE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         S_CAPTURE: begin
            cnt_next   = '0;
            state_next = ABORT ? S_IDLE : S_UNLOAD;
         end
         S_UNLOAD: begin
            if (ABORT) begin
               cnt_next   = '0;
               state_next = S_IDLE;
            end else if (cnt_reg == LAST) begin
               // Last bit arrives on this same edge, so take the merged value.
               cnt_next   = '0;
               resp_next  = shadow_next;
               state_next = S_FINISH;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         S_FINISH: begin
            cnt_next   = '0;
            state_next = S_IDLE;
         end
         default: begin
            cnt_next   = '0;
            state_next = S_IDLE;
         end
      endcase
   end

   assign SE   = (state_reg == S_SHIFT) || (state_reg == S_UNLOAD);
   assign SI   = (state_reg == S_SHIFT) ? pat_reg[rev_idx] : 1'b0;
   assign BUSY = (state_reg == S_SHIFT) || (state_reg == S_CAPTURE) ||
                 (state_reg == S_UNLOAD);
   assign DONE = (state_reg == S_FINISH);
   assign RESP = resp_reg;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: behavioural chain with selectable capture
// function, directed and random operations checked cycle by cycle.
module tb_scan_chain_ctrl;
   localparam int N = 4;

   logic         CLK = 1'b0;
   logic         RST, START, ABORT, SO;
   logic [N-1:0] PAT_IN, RESP;
   logic         SE, SI, BUSY, DONE;

   always #5 CLK = ~CLK;

   scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
      .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .PAT_IN(PAT_IN),
      .SO(SO), .SE(SE), .SI(SI), .BUSY(BUSY), .DONE(DONE), .RESP(RESP)
   );

   // Chain model: shift toward the tail when SE=1, functional load otherwise.
   logic [N-1:0] chain = '0;
   bit           cap_inv = 1'b0;
   always @(posedge CLK) begin
      if (SE) chain <= {chain[N-2:0], SI};
      else    chain <= cap_inv ? ~chain : chain;
   end
   assign SO = chain[N-1];

   int           errors = 0;
   int           checks = 0;
   int           cyc = 0;
   int           last_done = 0;
   logic [N-1:0] exp_resp = '0;

   task automatic step();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_SE"}, 32'(SE), 0);
      chk({tag, "_SI"}, 32'(SI), 0);
      chk({tag, "_BUSY"}, 32'(BUSY), 0);
      chk({tag, "_DONE"}, 32'(DONE), 0);
   endtask

   // One operation from the IDLE cycle; returns in the IDLE cycle that follows.
   task automatic run_op(input logic [N-1:0] pat, input bit inv, input int glitch_k,
                         input int abort_cyc, input int rst_cyc, input bit abort_w_start);
      logic [N-1:0] want;
      bit           e_shift, e_unload;
      want    = inv ? ~pat : pat;
      cap_inv = inv;
      PAT_IN  = pat;
      START   = 1'b1;
      ABORT   = abort_w_start;
      step();
      START   = 1'b0;
      ABORT   = 1'b0;
      PAT_IN  = N'($urandom);
      for (int c = 1; c <= 2*N+2; c++) begin
         e_shift  = (c <= N);
         e_unload = (c >= N+2) && (c <= 2*N+1);
         chk("SE", 32'(SE), 32'(e_shift || e_unload));
         chk("SI", 32'(SI), e_shift ? 32'(pat[N-c]) : 0);
         chk("BUSY", 32'(BUSY), 32'(c <= 2*N+1));
         chk("DONE", 32'(DONE), 32'(c == 2*N+2));
         chk("RESP", 32'(RESP), (c == 2*N+2) ? 32'(want) : 32'(exp_resp));
         if (c == 2*N+2) last_done = cyc;
         if (c == glitch_k + 1) begin
            START  = 1'b1;
            PAT_IN = ~pat;
         end
         if (c == abort_cyc) ABORT = 1'b1;
         if (c == rst_cyc) begin
            RST = 1'b1;
            step();
            step();
            RST = 1'b0;
            chk_idle("RST");
            chk("RST_RESP", 32'(RESP), 0);
            exp_resp = '0;
            return;
         end
         step();
         START = 1'b0;
         ABORT = 1'b0;
         if (c == abort_cyc && c <= 2*N+1) begin
            chk_idle("ABORT");
            for (int w = 0; w < 20; w++) begin
               chk("ABORT_DONE", 32'(DONE), 0);
               chk("ABORT_RESP", 32'(RESP), 32'(exp_resp));
               step();
            end
            return;
         end
      end
      exp_resp = want;
      chk_idle("POST");
      chk("POST_RESP", 32'(RESP), 32'(exp_resp));
   endtask

   initial begin
      int d1;
      RST = 1'b1; START = 1'b0; ABORT = 1'b0; PAT_IN = '0;
      step();
      step();
      RST = 1'b0;
      chk_idle("INIT");
      chk("INIT_RESP", 32'(RESP), 0);

      run_op(4'b1010, 1'b1, -1, 0, 0, 1'b0);
      run_op(4'b0001, 1'b0, -1, 0, 0, 1'b0);
      run_op(4'b1000, 1'b0, -1, 0, 0, 1'b0);
      step();
      run_op(4'b1010, 1'b1, 2, 0, 0, 1'b0);     // START ignored at SHIFT k=2
      run_op(4'b0011, 1'b0, -1, N+1, 0, 1'b0);  // ABORT in CAPTURE
      run_op(4'b1100, 1'b1, -1, 0, 0, 1'b1);    // START beats ABORT in IDLE

      run_op(4'b0110, 1'b0, -1, 0, 0, 1'b0);
      d1 = last_done;
      run_op(4'b1111, 1'b0, -1, 0, 0, 1'b0);
      chk("B2B_GAP", 32'(last_done - d1), 2*N+3);

      run_op(4'b0110, 1'b0, -1, 0, N+3, 1'b0);  // reset mid-UNLOAD
      run_op(4'b1001, 1'b1, -1, 0, 0, 1'b0);

      for (int i = 0; i < 12; i++) begin
         int ab;
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2*N+2)) : 0;
         run_op(N'($urandom), 1'($urandom_range(0, 1)), -1, ab, 0, 1'b0);
         repeat ($urandom_range(0, 2)) step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
